// File: rtl/xbar_pkg.sv
// xbar_pkg: FSM state type and helpers shared by the crossbar sequencing controller
package xbar_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, ADDR, RESP, RELEASE} state_t;
  localparam int BEAT_BYTES_LOG2 = 3;
  localparam int MAX_MASTER = 16;
  function automatic logic [4:0] size_to_beats(input logic [2:0] a_size);
    return (a_size > 3'(BEAT_BYTES_LOG2)) ? 5'd1 << (a_size - 3'(BEAT_BYTES_LOG2)) : 5'd1;
  endfunction
  // Scans downward so an illegal multi-hot grant resolves to its lowest set index
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTER-1:0] grant);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_MASTER - 1; i >= 0; i--) if (grant[i]) idx = 4'(i);
    return idx;
  endfunction
endpackage

// File: rtl/crossbar_ctl_if.sv
// crossbar_ctl_if: request/grant, muxed A/D handshakes and ownership strobes around the controller
interface crossbar_ctl_if #(parameter int NMASTER = 16);
  logic [NMASTER-1:0] request, grant;
  logic a_valid, a_ready, d_valid, d_ready;
  logic [2:0] a_size;
  logic set_owner, clr_owner, busy, timeout;
  logic [3:0] owner_id;
  modport master (
    input request, grant, a_valid, a_ready, a_size, d_valid, d_ready,
    output set_owner, clr_owner, busy, owner_id, timeout
  );
  modport slave (
    output request, grant, a_valid, a_ready, a_size, d_valid, d_ready,
    input set_owner, clr_owner, busy, owner_id, timeout
  );
endinterface

// File: rtl/xbar_wdog.sv
// xbar_wdog: response watchdog; expire flags the last counting cycle before a forced release
module xbar_wdog #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= cnt + TO_W'(1);
  assign expire = en && cnt == TO_W'(TIMEOUT - 1);
endmodule

// File: rtl/crossbar_ctl.sv
// crossbar_ctl: holds datapath ownership for one TileLink transaction (one A beat, all D beats)
module crossbar_ctl import xbar_pkg::*; #(
  parameter int NMASTER = 16,
  parameter int TIMEOUT = 1024,
  parameter int TO_W = $clog2(TIMEOUT)
) (
  input logic clk,
  input logic rst_n,
  crossbar_ctl_if.master bus
);
  state_t state;
  logic [4:0] beats;
  logic [NMASTER-1:0] gnt;
  logic a_fire, d_fire, wd_clr, wd_en, expire;
  assign gnt = bus.grant;
  assign a_fire = state == ADDR && bus.a_valid && bus.a_ready;
  assign d_fire = state == RESP && bus.d_valid && bus.d_ready;
  assign wd_clr = state == GRANT || a_fire || d_fire;
  assign wd_en = state == ADDR || state == RESP;
  assign bus.owner_id = onehot_to_idx(MAX_MASTER'(gnt));
  xbar_wdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wdog (
    .clk, .rst_n, .clr(wd_clr), .en(wd_en), .expire
  );
  // Fires are tested before expire so a handshake on the last watchdog cycle wins
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      beats <= '0;
      bus.set_owner <= 1'b0;
      bus.clr_owner <= 1'b0;
      bus.busy <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.set_owner <= 1'b0;
      bus.clr_owner <= 1'b0;
      bus.timeout <= 1'b0;
      case (state)
        IDLE: if (|bus.request) begin
          state <= GRANT;
          bus.set_owner <= 1'b1;
          bus.busy <= 1'b1;
        end
        GRANT: state <= ADDR;
        ADDR: if (~|gnt) begin
          state <= RELEASE;
          bus.clr_owner <= 1'b1;
        end else if (a_fire) begin
          state <= RESP;
          beats <= size_to_beats(bus.a_size);
        end else if (expire) begin
          state <= RELEASE;
          bus.clr_owner <= 1'b1;
          bus.timeout <= 1'b1;
        end
        RESP: if (d_fire) begin
          beats <= beats - 5'd1;
          if (beats == 5'd1) begin
            state <= RELEASE;
            bus.clr_owner <= 1'b1;
          end
        end else if (expire) begin
          state <= RELEASE;
          bus.clr_owner <= 1'b1;
          bus.timeout <= 1'b1;
        end
        RELEASE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
